// File: rtl/lb_pkg.sv
// Shared types and constants for the local-buffer FIFO controller.
package lb_pkg;
  localparam int LB_AW = 6;
  localparam int LB_DW = 128;
  localparam int LB_NB = 8;
  localparam int LB_AF = 56;

  typedef logic [LB_DW-1:0] lb_word_t;
  typedef logic [LB_AW-1:0] lb_addr_t;

  // SRAM write enables are active-low per 16-bit group
  localparam logic [LB_NB-1:0] LB_WE_ALL  = 8'h00;
  localparam logic [LB_NB-1:0] LB_WE_NONE = 8'hFF;
endpackage

// File: rtl/lb_out_skid.sv
// Two-entry register FIFO absorbing the SRAM read latency; head is e0.
module lb_out_skid
  import lb_pkg::*;
#(
  parameter int DW = LB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    cnt
);
  logic [DW-1:0] e0, e1;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // pop and push together: head advances, new word lands behind it
          if (cnt == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = e0;
endmodule

// File: rtl/lb_fifo_ctrl.sv
// Streams words through a 64x128 dual-port SRAM: port A writes, port B reads,
// with a 2-entry skid hiding the 1-cycle read latency.
module lb_fifo_ctrl
  import lb_pkg::*;
#(
  parameter int AW       = LB_AW,
  parameter int DW       = LB_DW,
  parameter int NB       = LB_NB,
  parameter int AF_LEVEL = LB_AF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [6:0]    count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          sram_oea,
  output logic          sram_oeb,
  output logic [NB-1:0] sram_wean,
  output logic [NB-1:0] sram_webn,
  output logic [AW-1:0] sram_a,
  output logic [AW-1:0] sram_b,
  output logic [DW-1:0] sram_dia,
  output logic [DW-1:0] sram_dib,
  input  logic [DW-1:0] sram_doa,
  input  logic [DW-1:0] sram_dob
);
  localparam logic [6:0] DEPTH = 7'(1 << AW);

  logic [AW-1:0] wptr, rptr;
  logic [6:0]    scnt, scnt_n, count_n;
  logic          pend, clr, pop, wr_go, iss;
  logic [1:0]    skid_cnt;
  logic [2:0]    inflight, skid_n;
  logic          unused_doa;

  assign unused_doa = ^sram_doa;
  assign sram_oea   = 1'b0;
  assign sram_webn  = LB_WE_NONE;
  assign sram_dib   = '0;

  lb_out_skid #(.DW(DW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (pend),
    .din  (sram_dob),
    .pop  (pop),
    .dout (rd_data),
    .cnt  (skid_cnt)
  );

  always_comb begin
    clr      = rst || flush;
    rd_valid = (skid_cnt != 2'd0);
    pop      = rd_valid && rd_ready;
    wr_ready = !clr && (scnt < DEPTH);
    wr_go    = wr_valid && wr_ready;
    // words already committed to the skid once this cycle's pop/capture settle
    inflight = 3'(skid_cnt) + 3'(pend) - 3'(pop);
    iss      = !clr && (scnt != 7'd0) && (inflight < 3'd2);

    sram_wean = wr_go ? LB_WE_ALL : LB_WE_NONE;
    sram_a    = clr ? '0 : wptr;
    sram_dia  = clr ? '0 : wr_data;
    sram_oeb  = iss;
    sram_b    = clr ? '0 : rptr;

    scnt_n  = clr ? 7'd0 : scnt + 7'(wr_go) - 7'(iss);
    skid_n  = clr ? 3'd0 : inflight;
    count_n = scnt_n + 7'(iss) + 7'(skid_n);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
      pend <= 1'b0;
    end else begin
      if (wr_go) wptr <= wptr + 1'b1;
      if (iss)   rptr <= rptr + 1'b1;
      pend <= iss;
    end
    scnt        <= scnt_n;
    count       <= count_n;
    full        <= (scnt_n == DEPTH);
    empty       <= (count_n == 7'd0);
    almost_full <= (count_n >= 7'(AF_LEVEL));
  end
endmodule
